// File: rtl/mc_pkg.sv
// Shared constants for the multicycle control FSM: state codes, opcodes and ALUOp codes.
// Optional feature macro: MC_ADDI_EN (adds the addi instruction path).
package mc_pkg;

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADR   = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE   = 4'd6;
    localparam logic [3:0] S_ALU_WB    = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_ADDI_EXEC = 4'd10;
    localparam logic [3:0] S_ADDI_WB   = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // State entered after DECODE; S_FETCH doubles as "opcode not recognised".
    function automatic logic [3:0] decode_target(input logic [5:0] op);
        logic [3:0] tgt;
        case (op)
            OP_LW, OP_SW: tgt = S_MEM_ADR;
            OP_RTYPE:     tgt = S_EXECUTE;
            OP_BEQ:       tgt = S_BRANCH;
            OP_J:         tgt = S_JUMP;
`ifdef MC_ADDI_EN
            OP_ADDI:      tgt = S_ADDI_EXEC;
`endif
            default:      tgt = S_FETCH;
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/mc_out_decode.sv
// State-to-control decode for the multicycle datapath; Moore outputs except the FETCH
// IRWrite/PCWrite gating on mem_ready. ADDI states decoded only with MC_ADDI_EN defined.
module mc_out_decode
    import mc_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp
);

    // Per-state control strobes; anything not set for a state stays low.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
            end
            S_MEM_ADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_RTYPE;
            end
            S_ALU_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
`ifdef MC_ADDI_EN
            S_ADDI_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDI_WB: begin
                RegWrite = 1'b1;
            end
`endif
            default: begin
                PCWrite = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: next-state logic and state/illegal-op registers.
// Define MC_ADDI_EN to add the addi path (opcode 001000); otherwise it is flagged illegal.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               IRWrite,
    output logic               ALUSrcA,
    output logic               RegWrite,
    output logic               RegDst,
    output logic [1:0]         PCSource,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    logic [STATE_W-1:0] state_r;
    logic [3:0]         cur_s;
    logic [3:0]         next_s;
    logic [3:0]         target_s;
    logic               illegal_s;
    logic               illegal_r;
    logic               is_sw_r;

    assign cur_s      = state_r[3:0];
    assign target_s   = decode_target(opcode);
    assign state      = state_r;
    assign illegal_op = illegal_r;

    // Next-state selection; memory states hold until mem_ready.
    always_comb begin
        next_s    = S_FETCH;
        illegal_s = 1'b0;
        case (cur_s)
            S_FETCH:     next_s = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                next_s    = target_s;
                illegal_s = (target_s == S_FETCH);
            end
            S_MEM_ADR:   next_s = is_sw_r ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  next_s = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: next_s = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   next_s = S_ALU_WB;
`ifdef MC_ADDI_EN
            S_ADDI_EXEC: next_s = S_ADDI_WB;
`endif
            default:     next_s = S_FETCH;
        endcase
    end

    // State and flag registers; the lw/sw choice is captured while the opcode is valid in DECODE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= STATE_W'(S_FETCH);
            illegal_r <= 1'b0;
            is_sw_r   <= 1'b0;
        end else begin
            state_r   <= STATE_W'(next_s);
            illegal_r <= illegal_s;
            if (cur_s == S_DECODE) begin
                is_sw_r <= (opcode == OP_SW);
            end else begin
                is_sw_r <= is_sw_r;
            end
        end
    end

    mc_out_decode u_out_decode (
        .state       (cur_s),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IRWrite     (IRWrite),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .PCSource    (PCSource),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp)
    );

endmodule
